// File: rtl/regfile16.sv
// Sixteen-entry register bank: one write port, two combinational read ports, and a valid/ready dump sequencer.
// Optional build macro REG0_ZERO_EN hardwires r0 to zero; writes to index 0 are then discarded.
module regfile16 #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [3:0]        rd_sel1,
    input  logic [3:0]        rd_sel2,
    output logic [WIDTH-1:0]  Out1,
    output logic [WIDTH-1:0]  Out2,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [3:0]        dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_regs [16];
    logic [WIDTH-1:0] w_view [16];
    logic             w_wr_allow;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_dump_idx;
    logic             w_last_beat;

`ifdef REG0_ZERO_EN
    assign w_wr_allow = (wr_sel != 4'd0);
`else
    assign w_wr_allow = 1'b1;
`endif

    // Register storage: reset to RESET_VAL, one write per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (wr_en && w_wr_allow) begin
            r_regs[wr_sel] <= wr_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Architectural view of the bank; index 0 is forced to zero when r0 is hardwired.
    always_comb begin
        w_view = r_regs;
`ifdef REG0_ZERO_EN
        w_view[0] = {WIDTH{1'b0}};
`endif
    end

    assign Out1      = w_view[rd_sel1];
    assign Out2      = w_view[rd_sel2];
    assign dump_data = w_view[r_dump_idx];
    assign dump_idx  = r_dump_idx;

    assign w_last_beat = dump_ready && (r_dump_idx == 4'd15);

    // Dump sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dump sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (dump_req) begin
                    w_state_nxt = S_DUMP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DUMP: begin
                if (w_last_beat) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DUMP;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat index: cleared when a dump starts, advanced on each accepted beat except the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dump_idx <= 4'd0;
        end else if ((r_state == S_IDLE) && dump_req) begin
            r_dump_idx <= 4'd0;
        end else if ((r_state == S_DUMP) && dump_ready && (r_dump_idx != 4'd15)) begin
            r_dump_idx <= r_dump_idx + 4'd1;
        end else begin
            r_dump_idx <= r_dump_idx;
        end
    end

    // Dump sequencer outputs decoded from the current state.
    always_comb begin
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                dump_valid = 1'b0;
                dump_busy  = 1'b0;
            end
            S_DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            S_DONE: begin
                dump_busy  = 1'b1;
                dump_done  = 1'b1;
            end
            default: begin
                dump_valid = 1'b0;
                dump_busy  = 1'b0;
                dump_done  = 1'b0;
            end
        endcase
    end

endmodule
